// File: rtl/gemm_core_p.sv
// Multi-lane multiply-accumulate core with a small weight memory, a two-stage
// issue pipeline and a serial readout of accumulator snapshots.
module gemm_core_p #(
   parameter int DW    = 16,
   parameter int DEPTH = 8,
   parameter int LANES = 4,
   parameter int ACCW  = 40,
   parameter int SAT   = 0,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  init,
   input  logic                  write,
   input  logic [AW-1:0]         wa,
   input  logic [LANES*DW-1:0]   wd,
   input  logic                  exec,
   input  logic [AW-1:0]         ra,
   input  logic [DW-1:0]         d,
   input  logic                  sgn,
   input  logic                  outr,
   output logic                  busy,
   output logic                  acc_valid,
   output logic [LW-1:0]         acc_lane,
   output logic [ACCW-1:0]       acc_out
);

   // state | meaning
   // IDLE  | no readout; outr accepted when the pipeline is empty
   // DUMP  | presenting snapshot lanes 0..LANES-1, one per cycle
   typedef enum logic {ST_IDLE, ST_DUMP} state_t;

   logic [LANES*DW-1:0] mem_q [DEPTH];

   logic                s1_vld_q, s1_init_q, s1_sgn_q;
   logic [LANES*DW-1:0] s1_w_q;
   logic [DW-1:0]       s1_d_q;

   logic                s2_vld_q, s2_init_q, s2_sgn_q;
   logic [ACCW-1:0]     prod_d    [LANES];
   logic [ACCW-1:0]     s2_prod_q [LANES];

   logic [ACCW-1:0]     acc_q  [LANES];
   logic [ACCW-1:0]     snap_q [LANES];

   state_t              state_q;
   logic                acc_valid_q;
   logic [LW-1:0]       acc_lane_q;
   logic [LW-1:0]       lane_nx;
   logic [ACCW-1:0]     acc_out_q;
   logic                issue;

   // Product of two DW-bit operands, extended to 2*DW and then to ACCW per sgn.
   function automatic logic [ACCW-1:0] mul_ext(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b,
                                               input logic          s);
      logic [2*DW-1:0] ax, bx, p;
      logic [ACCW-1:0] r;
      ax = s ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
      bx = s ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
      p  = ax * bx;
      r  = ACCW'(p);
      if (s && p[2*DW-1])
         r = r | ({ACCW{1'b1}} << (2*DW));
      return r;
   endfunction

   function automatic logic [ACCW-1:0] acc_add(input logic [ACCW-1:0] a,
                                               input logic [ACCW-1:0] p,
                                               input logic            s);
      logic [ACCW:0] sum;
      sum = {1'b0, a} + {1'b0, p};
      if (SAT == 0)
         return sum[ACCW-1:0];
      if (s) begin
         if ((a[ACCW-1] == p[ACCW-1]) && (sum[ACCW-1] != a[ACCW-1]))
            return a[ACCW-1] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
         return sum[ACCW-1:0];
      end
      return sum[ACCW] ? {ACCW{1'b1}} : sum[ACCW-1:0];
   endfunction

   // A write in the same cycle suppresses the MAC entirely.
   assign issue   = exec & ~write;
   assign lane_nx = acc_lane_q + LW'(1);

   always_ff @(posedge clk) begin
      if (write)
         mem_q[wa] <= wd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q  <= 1'b0;
         s1_init_q <= 1'b0;
         s1_sgn_q  <= 1'b0;
         s1_w_q    <= '0;
         s1_d_q    <= '0;
      end else begin
         s1_vld_q  <= issue;
         s1_init_q <= init;
         if (issue) begin
            s1_w_q   <= mem_q[ra];
            s1_d_q   <= d;
            s1_sgn_q <= sgn;
         end
      end
   end

   always_comb begin
      for (int l = 0; l < LANES; l++)
         prod_d[l] = mul_ext(s1_w_q[l*DW +: DW], s1_d_q, s1_sgn_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld_q  <= 1'b0;
         s2_init_q <= 1'b0;
         s2_sgn_q  <= 1'b0;
         for (int l = 0; l < LANES; l++)
            s2_prod_q[l] <= '0;
      end else begin
         s2_vld_q  <= s1_vld_q;
         s2_init_q <= s1_init_q;
         if (s1_vld_q) begin
            s2_sgn_q <= s1_sgn_q;
            for (int l = 0; l < LANES; l++)
               s2_prod_q[l] <= prod_d[l];
         end
      end
   end

   // init reaching the accumulate stage discards any MAC arriving with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int l = 0; l < LANES; l++)
            acc_q[l] <= '0;
      end else if (s2_init_q) begin
         for (int l = 0; l < LANES; l++)
            acc_q[l] <= '0;
      end else if (s2_vld_q) begin
         for (int l = 0; l < LANES; l++)
            acc_q[l] <= acc_add(acc_q[l], s2_prod_q[l], s2_sgn_q);
      end
   end

   assign busy = s1_vld_q | s1_init_q | s2_vld_q | s2_init_q | (state_q == ST_DUMP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         acc_valid_q <= 1'b0;
         acc_lane_q  <= '0;
         acc_out_q   <= '0;
         for (int l = 0; l < LANES; l++)
            snap_q[l] <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (outr && !busy) begin
                  snap_q      <= acc_q;
                  acc_lane_q  <= '0;
                  acc_out_q   <= acc_q[0];
                  acc_valid_q <= 1'b1;
                  state_q     <= ST_DUMP;
               end
            end
            ST_DUMP: begin
               if (acc_lane_q == LW'(LANES-1)) begin
                  acc_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end else begin
                  acc_lane_q <= lane_nx;
                  acc_out_q  <= snap_q[lane_nx];
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign acc_valid = acc_valid_q;
   assign acc_lane  = acc_lane_q;
   assign acc_out   = acc_out_q;

endmodule

// File: tb/tb_gemm_core_p.sv
// Scoreboard bench: a wrapping 40-bit instance and a saturating 32-bit instance
// share stimulus and are checked against an arithmetic reference model.
module tb_gemm_core_p;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        init = 1'b0, write = 1'b0, exec = 1'b0, sgn = 1'b0, outr = 1'b0;
   logic [2:0]  wa = '0, ra = '0;
   logic [63:0] wd = '0;
   logic [15:0] d = '0;
   logic        busy0, busy1, av0, av1;
   logic [1:0]  al0, al1;
   logic [39:0] ao0;
   logic [31:0] ao1;

   always #5 clk = ~clk;

   gemm_core_p #(.DW(16), .DEPTH(8), .LANES(4), .ACCW(40), .SAT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .init(init), .write(write), .wa(wa), .wd(wd),
      .exec(exec), .ra(ra), .d(d), .sgn(sgn), .outr(outr),
      .busy(busy0), .acc_valid(av0), .acc_lane(al0), .acc_out(ao0));

   gemm_core_p #(.DW(16), .DEPTH(8), .LANES(4), .ACCW(32), .SAT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .init(init), .write(write), .wa(wa), .wd(wd),
      .exec(exec), .ra(ra), .d(d), .sgn(sgn), .outr(outr),
      .busy(busy1), .acc_valid(av1), .acc_lane(al1), .acc_out(ao1));

   typedef struct {int lane; logic [39:0] v0; logic [31:0] v1;} exp_t;
   exp_t exp_q[$];

   int          n_tests = 0, n_fail = 0;
   int          edge_no = 0, last_pipe = -100, last_dump = -100;
   logic [15:0] mmem [8][4];
   longint      macc0 [4], macc1 [4];
   logic [39:0] last0;
   logic [31:0] last1;
   bit          have_last = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Reference MAC: true integer product and sum, then wrap or clamp to accw bits.
   function automatic longint mac(longint acc, logic [15:0] m, logic [15:0] x,
                                  bit s, int accw, bit sat);
      longint p, mask, half, a, sum;
      if (s) p = longint'($signed(m)) * longint'($signed(x));
      else   p = longint'({48'd0, m}) * longint'({48'd0, x});
      mask = (longint'(1) << accw) - 1;
      half = longint'(1) << (accw - 1);
      if (!sat) return (acc + p) & mask;
      if (s) begin
         a   = (acc ^ half) - half;
         sum = a + p;
         if (sum > half - 1) sum = half - 1;
         if (sum < -half)    sum = -half;
         return sum & mask;
      end
      sum = acc + p;
      if (sum > mask) sum = mask;
      return sum;
   endfunction

   function automatic bit model_busy();
      return ((edge_no - last_pipe) <= 2) || ((edge_no - last_dump) <= 4);
   endfunction

   function automatic logic [63:0] row4(logic [15:0] a3, logic [15:0] a2,
                                        logic [15:0] a1, logic [15:0] a0);
      return {a3, a2, a1, a0};
   endfunction

   task automatic model_reset();
      for (int l = 0; l < 4; l++) begin macc0[l] = 0; macc1[l] = 0; end
      last_pipe = -100;
      last_dump = -100;
   endtask

   task automatic step(input bit w, input logic [2:0] a, input logic [63:0] wdat,
                       input bit e, input logic [2:0] r, input logic [15:0] dd,
                       input bit s, input bit in, input bit o);
      bit mb;
      exp_t x;
      mb = model_busy();
      chk("busy0", {63'd0, busy0}, {63'd0, mb});
      chk("busy1", {63'd0, busy1}, {63'd0, mb});
      write = w; wa = a; wd = wdat; exec = e; ra = r; d = dd; sgn = s; init = in; outr = o;
      if (o && !mb) begin
         for (int l = 0; l < 4; l++) begin
            x.lane = l; x.v0 = macc0[l][39:0]; x.v1 = macc1[l][31:0];
            exp_q.push_back(x);
         end
         last_dump = edge_no;
      end
      if (w) begin
         for (int l = 0; l < 4; l++) mmem[a][l] = wdat[l*16 +: 16];
      end else if (e) begin
         for (int l = 0; l < 4; l++) begin
            macc0[l] = mac(macc0[l], mmem[r][l], dd, s, 40, 1'b0);
            macc1[l] = mac(macc1[l], mmem[r][l], dd, s, 32, 1'b1);
         end
         last_pipe = edge_no;
      end
      if (in) begin
         for (int l = 0; l < 4; l++) begin macc0[l] = 0; macc1[l] = 0; end
         last_pipe = edge_no;
      end
      @(posedge clk);
      edge_no++;
      #1;
      write = 0; exec = 0; init = 0; outr = 0; sgn = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic do_write(input logic [2:0] a, input logic [63:0] wdat);
      step(1, a, wdat, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic do_exec(input logic [2:0] r, input logic [15:0] dd, input bit s);
      step(0, 0, 0, 1, r, dd, s, 0, 0);
   endtask
   task automatic do_init();
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
   endtask
   task automatic drain();
      while (model_busy()) idle(1);
   endtask
   task automatic readout();
      drain();
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(5);
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      if (rst_n) begin
         if (av0 || av1) begin
            chk("valid_agree", {63'd0, av1}, {63'd0, av0});
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_valid: got lane %0d value %0h expected no output", al0, ao0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("lane0", {62'd0, al0}, 64'(mon_e.lane));
               chk("lane1", {62'd0, al1}, 64'(mon_e.lane));
               chk("acc0", {24'd0, ao0}, {24'd0, mon_e.v0});
               chk("acc1", {32'd0, ao1}, {32'd0, mon_e.v1});
            end
            last0 = ao0; last1 = ao1; have_last = 1;
         end else if (have_last) begin
            chk("hold0", {24'd0, ao0}, {24'd0, last0});
            chk("hold1", {32'd0, ao1}, {32'd0, last1});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, kind;
      logic [2:0] r;
      for (int i = 0; i < 8; i++) for (int l = 0; l < 4; l++) mmem[i][l] = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {62'd0, busy1, busy0}, 64'd0);
      chk("rst_valid", {62'd0, av1, av0}, 64'd0);
      chk("rst_out0", {24'd0, ao0}, 64'd0);
      chk("rst_out1", {32'd0, ao1}, 64'd0);
      chk("rst_lane", {60'd0, al1, al0}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // basic unsigned MAC: expect 5,10,15,20
      do_write(0, row4(4, 3, 2, 1));
      do_init();
      do_exec(0, 5, 0);
      readout();

      // signed vs unsigned lane0 0xFFFF * 2
      do_write(1, row4(0, 0, 0, 16'hFFFF));
      do_init();
      do_exec(1, 16'h0002, 1);
      readout();
      do_init();
      do_exec(1, 16'h0002, 0);
      readout();

      // back-to-back: every lane 36, then init right after the last exec
      for (int i = 0; i < 8; i++) do_write(3'(i), row4(1, 1, 1, 1));
      do_init();
      for (int i = 0; i < 8; i++) do_exec(3'(i), 16'(i + 1), 0);
      readout();
      for (int i = 0; i < 8; i++) do_exec(3'(i), 16'(i + 1), 0);
      do_init();
      readout();

      // collisions: write+exec, init+exec, outr while busy
      do_exec(0, 3, 0);
      step(1, 2, row4(9, 9, 9, 9), 1, 2, 7, 0, 0, 0);
      readout();
      do_exec(2, 4, 1);
      step(0, 0, 0, 1, 2, 4, 1, 1, 0);
      readout();
      do_exec(2, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      readout();

      // saturation: signed positive, signed negative, unsigned wrap/clamp
      do_write(4, row4(16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF));
      do_init();
      for (int i = 0; i < 6; i++) do_exec(4, 16'h7FFF, 1);
      readout();
      do_write(5, row4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
      do_init();
      for (int i = 0; i < 260; i++) do_exec(5, 16'hFFFF, 0);
      readout();

      // randomized mix, including outr issued while ops are still in flight
      for (int i = 0; i < 8; i++) do_write(3'(i), {$urandom, $urandom});
      do_init();
      for (int round = 0; round < 40; round++) begin
         n = $urandom_range(1, 12);
         for (int k = 0; k < n; k++) begin
            kind = $urandom_range(0, 11);
            r = 3'($urandom_range(0, 7));
            case (kind)
               0: do_write(r, {$urandom, $urandom});
               1: step(1, r, {$urandom, $urandom}, 1, r, 16'($urandom), 1'($urandom), 0, 0);
               2: do_init();
               3: step(0, 0, 0, 1, r, 16'($urandom), 1'($urandom), 1, 0);
               4: step(0, 0, 0, 1, r, 16'($urandom), 1'($urandom), 0, 1);
               5: idle(1);
               default: do_exec(r, 16'($urandom), 1'($urandom));
            endcase
         end
         readout();
      end

      // reset during DUMP lane 1 aborts the readout and clears the accumulators
      do_init();
      do_exec(0, 16'($urandom), 0);
      drain();
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      @(posedge clk); edge_no++; #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {62'd0, av1, av0}, 64'd0);
      chk("mid_rst_busy", {62'd0, busy1, busy0}, 64'd0);
      chk("mid_rst_out0", {24'd0, ao0}, 64'd0);
      chk("mid_rst_out1", {32'd0, ao1}, 64'd0);
      exp_q.delete();
      have_last = 0;
      model_reset();
      @(posedge clk); edge_no++; #1;
      rst_n = 1'b1;
      idle(4);
      readout();

      idle(3);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
